lsu_byte_seq: RTL and testbench
===============================

# lsu_byte_seq

Load/store sequencer for the multicycle core. It takes one load or store request from the datapath and drives the byte-wide scratchpad memory port, one byte per cycle in little-endian order. For loads it assembles the returned bytes and applies sign or zero extension. It returns a single-cycle response carrying the load data or an error flag.

## Interface
- MEM_BYTES, 32, scratchpad size in bytes; legal byte addresses are 0..MEM_BYTES-1.
- ADDR_W, 5, width of the memory-side address; must equal $clog2(MEM_BYTES).
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low n bytes are used.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  request rejected; valid with rsp_valid.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_en  out  1  memory byte access this cycle.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid one cycle after mem_en && !mem_we.

## Operation
- Access size n: funct3[1:0] = 00 gives n = 1, 01 gives n = 2, 10 gives n = 4.
- States and transitions:
  - IDLE: req_ready = 1. When req_valid is high, latch the request and go to CHECK.
  - CHECK: evaluate the request.
    - If the request is invalid, go to RESP with err = 1 and issue no memory access.
    - If the request is valid, clear the byte counter k and go to ACCESS.
  - ACCESS: drive mem_en = 1, mem_addr = addr + k, mem_we = req_we, and mem_wdata = wdata byte k.
    - While k < n-1, increment k and stay in ACCESS.
    - At k = n-1, a store goes to RESP and a load goes to LAST.
  - LAST: capture the final read byte, then go to RESP.
  - RESP: rsp_valid = 1, then go to IDLE.
- Invalid requests, any of:
  - funct3 is 011, 110 or 111;
  - req_we = 1 with funct3 = 100 or 101;
  - req_addr + n > MEM_BYTES, computed in 33-bit arithmetic so it cannot wrap;
  - misaligned address, only when LSU_ALIGN_CHECK_EN is defined.
- Load assembly: mem_rdata in the cycle after byte k was issued goes into assembly byte k. Bytes above n-1 are zero.
- Load extension, applied from a fully assembled value:
  - B sign-extends bit 7.
  - H sign-extends bit 15.
  - BU and HU zero-extend.
  - W is the word unchanged.
- Outputs outside the states listed above:
  - mem_en, mem_we, mem_addr and mem_wdata are 0 in every state except ACCESS.
  - rsp_rdata and rsp_err are 0 except in RESP.
- There is no response backpressure; the consumer must take the response in the RESP cycle.

## Timing
- Request handshake in cycle 0 (req_valid and req_ready both high); CHECK is cycle 1.
- Store: ACCESS in cycles 2..n+1, rsp_valid in cycle n+2. A SW therefore responds in cycle 6.
- Load: ACCESS in cycles 2..n+1, LAST in cycle n+2, rsp_valid in cycle n+3. An LW therefore responds in cycle 7.
- Error: rsp_valid with rsp_err = 1 in cycle 2.
- req_ready rises again in the cycle after RESP. Back-to-back requests are spaced at least n+3 cycles (store) or n+4 cycles (load) apart.
- Reset:
  - Every output except req_ready is 0 in the cycle after rst is sampled high.
  - req_ready = 1, because the block is in IDLE.
  - Reset mid-operation aborts the transfer. Bytes already written stay in memory. No response is issued.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - A halfword access with addr[0] ≠ 0 is rejected with rsp_err.
  - A word access with addr[1:0] ≠ 0 is rejected with rsp_err.
- LSU_ALIGN_CHECK_EN undefined: misaligned accesses are legal and split byte-by-byte like any other access. The range check still applies.

## Structure
- Package lsu_pkg contains:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum lsu_state_t (IDLE, CHECK, ACCESS, LAST, RESP);
  - the size-decode function returning n.
- One sub-module, lsu_load_extend: purely combinational. It takes the 32-bit assembly value and funct3 and produces rsp_rdata.

## Test plan
- Store then load: SW 0xDEADBEEF to address 4, then LW from address 4.
  - The memory must see writes EF, BE, AD, DE to addresses 4..7 in cycles 2..5.
  - The store's rsp_valid must be in cycle 6.
  - The load must return rsp_rdata = 0xDEADBEEF in cycle 7.
- Sign and zero extension: memory address 8 holds 0x80 and address 9 holds 0xFF.
  - LB 8 returns 0xFFFFFF80; LBU 8 returns 0x00000080.
  - LH 8 returns 0xFFFFFF80; LHU 8 returns 0x0000FF80.
- Range: LW 29 and SH 31 give rsp_err = 1 in cycle 2, with mem_en never asserted. SB 31 succeeds.
- Illegal funct3: funct3 = 011, and a store with funct3 = 100, each give rsp_err = 1 with rsp_rdata = 0.
- Misalignment: SW to address 2.
  - With LSU_ALIGN_CHECK_EN defined, the result is rsp_err.
  - Without it, addresses 2..5 are written and a following LW 2 reads the value back.
- Reset mid-operation: assert rst in cycle 3 of an SW to address 0.
  - The following cycle shows mem_en = 0 and req_ready = 1.
  - No rsp_valid follows.
  - Bytes 0 and 1 are written; bytes 2 and 3 are unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store sequencer: access-type
// codes, FSM state encoding and access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ACCESS = 3'd2,
    LAST   = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

  // Number of bytes moved for an access type (1, 2 or 4).
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
    case (funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational sign/zero extension of an assembled little-endian load value.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] asm_data,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = asm_data;
    case (funct3)
      F3_B:    rdata = {{24{asm_data[7]}}, asm_data[7:0]};
      F3_H:    rdata = {{16{asm_data[15]}}, asm_data[15:0]};
      F3_BU:   rdata = {24'b0, asm_data[7:0]};
      F3_HU:   rdata = {16'b0, asm_data[15:0]};
      default: rdata = asm_data;
    endcase
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer driving a byte-wide scratchpad.
// Define LSU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module lsu_byte_seq
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  // Request is taken on a cycle where req_valid && req_ready; the request
  // fields need only be stable in that cycle. Responses have no ready.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [2:0]        dbg_state
);

  lsu_state_t  state_q, state_d;
  logic        op_we_q;
  logic [2:0]  op_f3_q;
  logic [31:0] op_addr_q;
  logic [31:0] op_wdata_q;
  logic [1:0]  k_q, k_d;
  logic        err_q;
  logic [31:0] asm_q;
  logic        rd_valid_q;
  logic [1:0]  rd_idx_q;

  logic [2:0]  n;
  logic        last_byte;
  logic [32:0] end_addr;
  logic        out_of_range;
  logic        misaligned;
  logic        invalid;
  logic [31:0] ext_data;

  assign n            = size_bytes(op_f3_q);
  assign last_byte    = ({1'b0, k_q} == (n - 3'd1));
  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign end_addr     = {1'b0, op_addr_q} + {30'b0, n};
  assign out_of_range = end_addr > 33'(MEM_BYTES);

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((n == 3'd2) && op_addr_q[0]) ||
                      ((n == 3'd4) && (op_addr_q[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign invalid   = !f3_legal(op_f3_q, op_we_q) || out_of_range || misaligned;
  assign dbg_state = state_q;

  lsu_load_extend u_extend (
    .asm_data (asm_q),
    .funct3   (op_f3_q),
    .rdata    (ext_data)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = CHECK;
      end
      CHECK: begin
        k_d     = 2'd0;
        state_d = invalid ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = op_we_q;
        mem_addr  = op_addr_q[ADDR_W-1:0] + ADDR_W'(k_q);
        mem_wdata = op_wdata_q[{k_q, 3'b000} +: 8];
        if (last_byte) state_d = op_we_q ? RESP : LAST;
        else           k_d     = k_q + 2'd1;
      end
      LAST: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || op_we_q) ? 32'b0 : ext_data;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_we_q    <= 1'b0;
      op_f3_q    <= 3'b0;
      op_addr_q  <= 32'b0;
      op_wdata_q <= 32'b0;
      k_q        <= 2'd0;
      err_q      <= 1'b0;
      asm_q      <= 32'b0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (state_q == IDLE && req_valid) begin
        op_we_q    <= req_we;
        op_f3_q    <= req_funct3;
        op_addr_q  <= req_addr;
        op_wdata_q <= req_wdata;
      end
      if (state_q == CHECK) begin
        err_q <= invalid;
        asm_q <= 32'b0;
      end
      // Read data returns one cycle after issue; remember which byte it is.
      rd_valid_q <= mem_en && !mem_we;
      rd_idx_q   <= k_q;
      if (rd_valid_q) asm_q[{rd_idx_q, 3'b000} +: 8] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed bench for lsu_byte_seq with a behavioural byte scratchpad.
// Honours LSU_ALIGN_CHECK_EN for the misaligned-store case.
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [32];
  logic [20:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  lsu_byte_seq #(.MEM_BYTES(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected write: {cycle, address, byte}
  task automatic exp_write(input int cyc, input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back({cyc[7:0], a, d});
  endtask

  // driver: issue one request, run to the response, report latency/result
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] rdata, output logic saw_en);
    int got_rsp;
    logic [20:0] e;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1; got_rsp = 0; saw_en = 1'b0; err = 1'b0; rdata = 32'b0;
    while (!got_rsp && lat < 20) begin
      @(negedge clk);
      if (mem_en) saw_en = 1'b1;
      if (mem_en && mem_we) begin
        if (exp_q.size() == 0) begin
          chk("write_unexpected", {27'b0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("write", {11'b0, lat[7:0], mem_addr, mem_wdata}, {11'b0, e});
        end
      end
      if (rsp_valid) begin
        got_rsp = 1; err = rsp_err; rdata = rsp_rdata;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!got_rsp) chk("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
    chk("write_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  int          lat;
  logic        err, saw_en;
  logic [31:0] rd;
  int          stray;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_outs", {18'b0, mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    rst = 1'b0;

    // SW 0xDEADBEEF @4, then LW @4
    exp_write(2, 5'd4, 8'hEF); exp_write(3, 5'd5, 8'hBE);
    exp_write(4, 5'd6, 8'hAD); exp_write(5, 5'd7, 8'hDE);
    do_req(1'b1, 3'b010, 32'd4, 32'hDEADBEEF, lat, err, rd, saw_en);
    chk("sw_lat", lat, 6);
    chk("sw_err", {31'b0, err}, 0);
    chk("sw_rdata", rd, 0);
    do_req(1'b0, 3'b010, 32'd4, 32'h0, lat, err, rd, saw_en);
    chk("lw_lat", lat, 7);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'b0, err}, 0);

    // sign / zero extension
    mem[8] = 8'h80; mem[9] = 8'hFF;
    do_req(1'b0, 3'b000, 32'd8, 32'h0, lat, err, rd, saw_en);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    chk("lb_lat", lat, 4);
    do_req(1'b0, 3'b100, 32'd8, 32'h0, lat, err, rd, saw_en);
    chk("lbu_rdata", rd, 32'h00000080);
    do_req(1'b0, 3'b001, 32'd8, 32'h0, lat, err, rd, saw_en);
    chk("lh_rdata", rd, 32'hFFFFFF80);
    chk("lh_lat", lat, 5);
    do_req(1'b0, 3'b101, 32'd8, 32'h0, lat, err, rd, saw_en);
    chk("lhu_rdata", rd, 32'h0000FF80);

    // range
    do_req(1'b0, 3'b010, 32'd29, 32'h0, lat, err, rd, saw_en);
    chk("lw29_err", {31'b0, err}, 1);
    chk("lw29_lat", lat, 2);
    chk("lw29_no_mem", {31'b0, saw_en}, 0);
    do_req(1'b1, 3'b001, 32'd31, 32'h1234, lat, err, rd, saw_en);
    chk("sh31_err", {31'b0, err}, 1);
    chk("sh31_lat", lat, 2);
    chk("sh31_no_mem", {31'b0, saw_en}, 0);
    exp_write(2, 5'd31, 8'h5A);
    do_req(1'b1, 3'b000, 32'd31, 32'hFFFF_FF5A, lat, err, rd, saw_en);
    chk("sb31_err", {31'b0, err}, 0);
    chk("sb31_lat", lat, 3);
    chk("sb31_mem", {24'b0, mem[31]}, 32'h5A);
    do_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, lat, err, rd, saw_en);
    chk("lw_wrap_err", {31'b0, err}, 1);

    // illegal funct3
    do_req(1'b0, 3'b011, 32'd0, 32'h0, lat, err, rd, saw_en);
    chk("f3_011_err", {31'b0, err}, 1);
    chk("f3_011_rdata", rd, 0);
    chk("f3_011_no_mem", {31'b0, saw_en}, 0);
    do_req(1'b1, 3'b100, 32'd0, 32'hFFFF_FFFF, lat, err, rd, saw_en);
    chk("sbu_err", {31'b0, err}, 1);
    chk("sbu_rdata", rd, 0);

    // misaligned SW @2
`ifdef LSU_ALIGN_CHECK_EN
    do_req(1'b1, 3'b010, 32'd2, 32'h12345678, lat, err, rd, saw_en);
    chk("sw2_err", {31'b0, err}, 1);
    chk("sw2_no_mem", {31'b0, saw_en}, 0);
`else
    exp_write(2, 5'd2, 8'h78); exp_write(3, 5'd3, 8'h56);
    exp_write(4, 5'd4, 8'h34); exp_write(5, 5'd5, 8'h12);
    do_req(1'b1, 3'b010, 32'd2, 32'h12345678, lat, err, rd, saw_en);
    chk("sw2_err", {31'b0, err}, 0);
    do_req(1'b0, 3'b010, 32'd2, 32'h0, lat, err, rd, saw_en);
    chk("lw2_rdata", rd, 32'h12345678);
`endif

    // reset in cycle 3 of SW @0
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd0;
    req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_in_access", {31'b0, mem_en}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 1);
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    chk("rst_mid_no_rsp", stray, 0);
    chk("rst_mid_bytes", {mem[3], mem[2], mem[1], mem[0]}, 32'h4433BABE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
